zet_pic: RTL
============

Name: zet_pic

Overview:
- Single-clock 8-input programmable interrupt controller, a cut-down 8259A.
- Sits directly upstream of the CPU interrupt handshake and replaces the fixed vector-9 mux in the top level.
- Latches edge requests from the keyboard, timer and other sources, and raises one interrupt line to the CPU.
- Supplies the vector when the CPU acknowledges, tracks in-service levels, and is programmed through I/O ports 0x20/0x21 over the Wishbone bus.

Parameters:
- VEC_BASE, 8'h08, vector for IRQ0; IRQn yields VEC_BASE+n (timer=8, keyboard=9).
- IMR_RST, 8'hFF, mask register value after reset (all masked).

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge.
- wb_rst_i  in  1  reset, asynchronous, active-low.
- wb_dat_i  in  16  write data; [7:0]=port 0x20, [15:8]=port 0x21.
- wb_dat_o  out  16  read data, same byte mapping.
- wb_sel_i  in  2  byte enables; sel[0]=port 0x20, sel[1]=port 0x21.
- wb_we_i  in  1  write strobe qualifier.
- wb_stb_i  in  1  strobe; the top level decodes tga & adr[15:1]==15'h0010.
- wb_cyc_i  in  1  cycle.
- wb_ack_o  out  1  registered acknowledge.
- irq_i  in  8  request lines, synchronous to wb_clk_i; bit0 has the highest priority.
- intr_o  out  1  interrupt request to the CPU (wb_tgc_i).
- inta_i  in  1  acknowledge from the CPU (wb_tgc_o), held high for the vector fetch.
- vec_o  out  8  interrupt vector, valid while inta_i is high.

Behaviour:
- Reset (wb_rst_i=0, async):
  - IRR=0, ISR=0, IMR=IMR_RST, irq_prev=0, rd_isr=0.
  - wb_ack_o=0, intr_o=0, vec_o=VEC_BASE+7, inta_prev=0.
- Request capture: IRR[n] is set on a cycle where irq_i[n]=1 and irq_prev[n]=0. A level held high never re-triggers.
- Priority: winner = lowest-numbered bit of IRR & ~IMR. Ceiling = lowest-numbered ISR bit, or 8 if ISR=0.
- intr_o is registered. Next value = 1 iff a winner exists, its index < ceiling, and no acknowledge is in progress (inta_i=0).
- Acknowledge, on the first cycle inta_i=1 with inta_prev=0:
  - With a winner w: IRR[w]<=0, ISR[w]<=1, vec_o<=VEC_BASE+w.
  - Without a winner (spurious): vec_o<=VEC_BASE+7, and IRR/ISR are unchanged.
  - intr_o<=0 in both cases. vec_o holds until the next acknowledge.
- Same-cycle rules:
  - A new edge on bit w in the acknowledge cycle wins over the clear, so IRR[w] stays 1.
  - An IMR write in the acknowledge cycle takes effect after it; the acknowledge uses the old IMR.
- Wishbone:
  - wb_ack_o <= stb & cyc & ~wb_ack_o, giving a one-cycle pulse one cycle after the strobe, zero wait beyond that.
  - Writes commit in the cycle wb_ack_o is 1 (stb&cyc&we&ack).
  - wb_dat_o is combinational: {IMR, rd_isr ? ISR : IRR}.
- Port 0x20 writes (sel[0]):
  - 8'h20: non-specific EOI, clears the lowest-numbered ISR bit; no-op if ISR=0.
  - 8'h60|n: specific EOI, clears ISR[n].
  - 8'h0A: rd_isr<=0. 8'h0B: rd_isr<=1.
  - Other values: ignored (ICW sequences are not supported; vector base is fixed by VEC_BASE).
- Port 0x21 writes (sel[1]): IMR<=wb_dat_i[15:8].
- Both bytes written in one access: EOI and IMR updates apply together.
- An EOI in the same cycle as an acknowledge setting the same ISR bit: the set wins.
- After an EOI, intr_o re-evaluates on the next cycle. A masked pending request stays in IRR and fires once unmasked.
- Reset mid-acknowledge or mid-bus-cycle clears everything immediately. The CPU sees no ack and intr_o=0.

Test Plan:
- Reset, then read word 0x20 -> wb_dat_o=16'hFF00; ack exactly one cycle after stb. Write IMR=8'hFC, read back -> 16'hFC00.
- IMR=8'hFC, pulse irq_i[1] -> intr_o=1 two cycles later. Raise inta_i -> intr_o=0, vec_o=8'h09, ISR=8'h02; with 0x20 written 8'h0B, read -> 16'hFC02.
- IRQ1 in service, pulse irq_i[0] -> intr_o=1. Acknowledge -> vec_o=8'h08, ISR=8'h03. EOI 8'h20 -> ISR=8'h02. EOI again -> ISR=0.
- IRQ0 in service, pulse irq_i[1] -> intr_o stays 0 until EOI. Then intr_o=1 and vec_o=8'h09 on acknowledge.
- IMR=8'hFF, pulse irq_i[1] -> no intr_o, IRR=8'h02. Write IMR=8'hFD -> intr_o=1. Raise inta_i with IMR=FF written the same cycle -> still vec_o=8'h09.
- Raise inta_i with no pending request -> vec_o=8'h0F, ISR=0. Hold irq_i[0] high for 20 cycles -> exactly one IRR set. Assert reset during inta_i -> all state cleared asynchronously.

Source files
------------

// File: rtl/zet_pic.sv
// zet_pic: 8-input programmable interrupt controller (reduced 8259A).
// Edge-triggered requests, fixed priority (IRQ0 highest), in-service nesting,
// vector supplied on CPU acknowledge, programmed via ports 0x20/0x21.
module zet_pic #(
  parameter logic [7:0] VEC_BASE = 8'h08,
  parameter logic [7:0] IMR_RST  = 8'hFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic [7:0]  irq_i,
  output logic        intr_o,
  input  logic        inta_i,
  output logic [7:0]  vec_o
);

  localparam int unsigned NIRQ = 8;
  localparam int unsigned IW   = 3;

  logic [7:0] irr_q, irr_d;
  logic [7:0] isr_q, isr_d;
  logic [7:0] imr_q, imr_d;
  logic [7:0] irq_prev_q, irq_prev_d;
  logic       rd_isr_q, rd_isr_d;
  logic       ack_q, ack_d;
  logic       intr_q, intr_d;
  logic [7:0] vec_q, vec_d;
  logic       inta_prev_q, inta_prev_d;

  logic [7:0]    pend;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW:0]   ceil_idx;
  logic          wr, wr_lo, wr_hi, ack_start;
  logic [7:0]    irq_edge;

  // Pick the highest-priority unmasked request and the in-service ceiling.
  always_comb begin
    pend      = irr_q & ~imr_q;
    win_found = 1'b0;
    win_idx   = '0;
    ceil_idx  = (IW+1)'(NIRQ);
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pend[i]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
      end
      if (isr_q[i]) begin
        ceil_idx = (IW+1)'(i);
      end
    end
  end

  // Next-state logic: request capture, acknowledge, EOI and register writes.
  always_comb begin
    wr        = wb_stb_i & wb_cyc_i & wb_we_i & ack_q;
    wr_lo     = wr & wb_sel_i[0];
    wr_hi     = wr & wb_sel_i[1];
    ack_start = inta_i & ~inta_prev_q;
    irq_edge  = irq_i & ~irq_prev_q;

    irr_d       = irr_q;
    isr_d       = isr_q;
    imr_d       = imr_q;
    rd_isr_d    = rd_isr_q;
    vec_d       = vec_q;
    irq_prev_d  = irq_i;
    inta_prev_d = inta_i;
    ack_d       = wb_stb_i & wb_cyc_i & ~ack_q;
    intr_d      = win_found & ({1'b0, win_idx} < ceil_idx) & ~inta_i;

    // A fresh edge in the acknowledge cycle re-arms the request being cleared.
    if (ack_start && win_found) begin
      irr_d[win_idx] = 1'b0;
    end
    irr_d = irr_d | irq_edge;

    // EOI first so that a simultaneous acknowledge set on the same bit wins.
    if (wr_lo) begin
      if (wb_dat_i[7:0] == 8'h20) begin
        isr_d = isr_q & (isr_q - 8'd1);
      end else if (wb_dat_i[7:3] == 5'b01100) begin
        isr_d[wb_dat_i[2:0]] = 1'b0;
      end
      if (wb_dat_i[7:0] == 8'h0A) begin
        rd_isr_d = 1'b0;
      end else if (wb_dat_i[7:0] == 8'h0B) begin
        rd_isr_d = 1'b1;
      end
    end
    if (ack_start && win_found) begin
      isr_d[win_idx] = 1'b1;
    end

    if (wr_hi) begin
      imr_d = wb_dat_i[15:8];
    end

    if (ack_start) begin
      vec_d = win_found ? 8'(VEC_BASE + {5'b0, win_idx}) : 8'(VEC_BASE + 8'd7);
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      irr_q       <= '0;
      isr_q       <= '0;
      imr_q       <= IMR_RST;
      irq_prev_q  <= '0;
      rd_isr_q    <= 1'b0;
      ack_q       <= 1'b0;
      intr_q      <= 1'b0;
      vec_q       <= 8'(VEC_BASE + 8'd7);
      inta_prev_q <= 1'b0;
    end else begin
      irr_q       <= irr_d;
      isr_q       <= isr_d;
      imr_q       <= imr_d;
      irq_prev_q  <= irq_prev_d;
      rd_isr_q    <= rd_isr_d;
      ack_q       <= ack_d;
      intr_q      <= intr_d;
      vec_q       <= vec_d;
      inta_prev_q <= inta_prev_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign intr_o   = intr_q;
  assign vec_o    = vec_q;
  assign wb_dat_o = {imr_q, rd_isr_q ? isr_q : irr_q};

endmodule
